// File: rtl/duel_projectile_engine.sv
// Two-player lane-duel engine: projectile slots, clash/hit resolution, shields,
// cooldowns and the IDLE/PLAY/OVER round controller.

// Per-slot game step: advance one pixel, despawn at the far edge, flag hit zone
module duel_slot_move #(
  parameter int X_W     = 7,
  parameter int BALL_W  = 7,
  parameter int FIELD_W = 96,
  parameter int SPAWN_X = 17,
  parameter int HIT_X   = 72,
  parameter bit IS_P1   = 1'b1
) (
  input  logic           en,
  input  logic [X_W-1:0] x,
  output logic           mv_en,
  output logic [X_W-1:0] mv_x,
  output logic           in_hit
);
  // P1 shots travel right and test their right edge; P2 shots travel left
  always_comb begin
    mv_en  = en;
    mv_x   = x;
    in_hit = 1'b0;
    if (en) begin
      if (IS_P1) begin
        in_hit = (int'(x) + BALL_W >= HIT_X);
        if (int'(x) + BALL_W >= FIELD_W - 2) begin
          mv_en = 1'b0;
          mv_x  = X_W'(SPAWN_X);
        end else begin
          mv_x = x + X_W'(1);
        end
      end else begin
        in_hit = (int'(x) <= HIT_X);
        if (int'(x) <= 1) begin
          mv_en = 1'b0;
          mv_x  = X_W'(SPAWN_X);
        end else begin
          mv_x = x - X_W'(1);
        end
      end
    end
  end
endmodule

module duel_projectile_engine #(
  parameter int LANES      = 3,
  parameter int SLOTS      = 3,
  parameter int X_W        = 7,
  parameter int BALL_W     = 7,
  parameter int P1_SPAWN_X = 17,
  parameter int P2_SPAWN_X = 74,
  parameter int P1_HIT_X   = 23,
  parameter int P2_HIT_X   = 72,
  parameter int FIELD_W    = 96,
  parameter int MAX_HP     = 5,
  localparam int LW        = $clog2(LANES),
  localparam int N         = LANES * SLOTS,
  localparam int HP_W      = $clog2(MAX_HP + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             p1_up,
  input  logic             p1_down,
  input  logic             p2_up,
  input  logic             p2_down,
  input  logic             p1_shoot,
  input  logic             p2_shoot,
  input  logic [5:0]       cooldown_ticks,
  input  logic [7:0]       shield_thresh_p1,
  input  logic [7:0]       shield_thresh_p2,
  input  logic [7:0]       random_number,
  output logic [1:0]       state,
  output logic [1:0]       winner,
  output logic [LW-1:0]    p1_lane,
  output logic [LW-1:0]    p2_lane,
  output logic [N-1:0]     p1_ball_en,
  output logic [N-1:0]     p2_ball_en,
  output logic [N*X_W-1:0] p1_ball_x,
  output logic [N*X_W-1:0] p2_ball_x,
  output logic [HP_W-1:0]  p1_hp,
  output logic [HP_W-1:0]  p2_hp,
  output logic [6:0]       p1_health_pct,
  output logic [6:0]       p2_health_pct,
  output logic             p1_shield,
  output logic             p2_shield,
  output logic [1:0]       shot_drop
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_PLAY = 2'b01, S_OVER = 2'b10} state_t;

  localparam logic [N-1:0][X_W-1:0] X1_INIT = {N{X_W'(P1_SPAWN_X)}};
  localparam logic [N-1:0][X_W-1:0] X2_INIT = {N{X_W'(P2_SPAWN_X)}};
  localparam logic [LW-1:0]         LANE0   = LW'(LANES / 2);
  localparam logic [HP_W-1:0]       HP0     = HP_W'(MAX_HP);

  state_t                st_q, st_d;
  logic [1:0]            win_q, win_d, drop_q, drop_d;
  logic [LW-1:0]         lane1_q, lane1_d, lane2_q, lane2_d;
  logic [N-1:0]          en1_q, en1_d, en2_q, en2_d;
  logic [N-1:0][X_W-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [HP_W-1:0]       hp1_q, hp1_d, hp2_q, hp2_d;
  logic [5:0]            cd1_q, cd1_d, cd2_q, cd2_d, cd_load;
  logic                  sh1_q, sh1_d, sh2_q, sh2_d;

  logic [N-1:0]          m1_en, m2_en, z1, z2, clash1, clash2, hit1, hit2;
  logic [N-1:0]          a1, a2, f1, f2;
  logic [N-1:0][X_W-1:0] m1_x, m2_x;
  int                    nh1, nh2;

  assign cd_load = (cooldown_ticks == 6'd0) ? 6'd1 : cooldown_ticks;

  for (genvar s = 0; s < N; s++) begin : g_slot
    duel_slot_move #(.X_W(X_W), .BALL_W(BALL_W), .FIELD_W(FIELD_W),
                     .SPAWN_X(P1_SPAWN_X), .HIT_X(P2_HIT_X), .IS_P1(1'b1))
      u_p1 (.en(en1_q[s]), .x(x1_q[s]), .mv_en(m1_en[s]), .mv_x(m1_x[s]), .in_hit(z1[s]));
    duel_slot_move #(.X_W(X_W), .BALL_W(BALL_W), .FIELD_W(FIELD_W),
                     .SPAWN_X(P2_SPAWN_X), .HIT_X(P1_HIT_X), .IS_P1(1'b0))
      u_p2 (.en(en2_q[s]), .x(x2_q[s]), .mv_en(m2_en[s]), .mv_x(m2_x[s]), .in_hit(z2[s]));
  end

  // Lowest-index free slot of a lane, one-hot (zero when the lane is full)
  function automatic logic [N-1:0] pick_slot(input logic [N-1:0] busy, input logic [LW-1:0] lane);
    pick_slot = '0;
    for (int i = N - 1; i >= 0; i--)
      if ((i / SLOTS == int'(lane)) && !busy[i]) begin
        pick_slot    = '0;
        pick_slot[i] = 1'b1;
      end
  endfunction

  function automatic int count_ones(input logic [N-1:0] v);
    count_ones = 0;
    for (int i = 0; i < N; i++) count_ones += int'(v[i]);
  endfunction

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp, input int n);
    sat_sub = (n >= int'(hp)) ? '0 : HP_W'(int'(hp) - n);
  endfunction

  // Clash and hit detection, all on pre-tick positions and lanes
  always_comb begin
    clash1 = '0;
    clash2 = '0;
    hit1   = '0;
    hit2   = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (en1_q[i] && en2_q[j] && (i / SLOTS == j / SLOTS) &&
            (int'(x1_q[i]) + BALL_W + 1 >= int'(x2_q[j]))) begin
          clash1[i] = 1'b1;
          clash2[j] = 1'b1;
        end
    for (int i = 0; i < N; i++) begin
      hit1[i] = en1_q[i] && !clash1[i] && z1[i] && (i / SLOTS == int'(lane2_q));
      hit2[i] = en2_q[i] && !clash2[i] && z2[i] && (i / SLOTS == int'(lane1_q));
    end
  end

  // Round controller and tick commit: everything lands in one clock
  always_comb begin
    st_d = st_q;     win_d = win_q;
    lane1_d = lane1_q; lane2_d = lane2_q;
    en1_d = en1_q;   en2_d = en2_q;
    x1_d = x1_q;     x2_d = x2_q;
    hp1_d = hp1_q;   hp2_d = hp2_q;
    cd1_d = cd1_q;   cd2_d = cd2_q;
    sh1_d = 1'b0;    sh2_d = 1'b0;
    drop_d = 2'b00;
    a1 = m1_en & ~clash1 & ~hit1;
    a2 = m2_en & ~clash2 & ~hit2;
    f1 = pick_slot(a1, lane1_q);
    f2 = pick_slot(a2, lane2_q);
    nh1 = count_ones(hit1);
    nh2 = count_ones(hit2);
    unique case (st_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          st_d = S_PLAY;   win_d = 2'b00;
          lane1_d = LANE0; lane2_d = LANE0;
          en1_d = '0;      en2_d = '0;
          x1_d = X1_INIT;  x2_d = X2_INIT;
          hp1_d = HP0;     hp2_d = HP0;
          cd1_d = '0;      cd2_d = '0;
        end
      end
      S_PLAY: begin
        if (p1_up) begin
          if (lane1_q != '0) lane1_d = lane1_q - LW'(1);
        end else if (p1_down && int'(lane1_q) < LANES - 1) lane1_d = lane1_q + LW'(1);
        if (p2_up) begin
          if (lane2_q != '0) lane2_d = lane2_q - LW'(1);
        end else if (p2_down && int'(lane2_q) < LANES - 1) lane2_d = lane2_q + LW'(1);
        if (tick) begin
          for (int i = 0; i < N; i++) begin
            x1_d[i] = a1[i] ? m1_x[i] : X_W'(P1_SPAWN_X);
            x2_d[i] = a2[i] ? m2_x[i] : X_W'(P2_SPAWN_X);
          end
          en1_d = a1;
          en2_d = a2;
          // P1 hits land on P2 and are shielded by P2's threshold, and vice versa
          if (nh1 != 0) begin
            if (random_number < shield_thresh_p2) sh2_d = 1'b1;
            else hp2_d = sat_sub(hp2_q, nh1);
          end
          if (nh2 != 0) begin
            if (random_number < shield_thresh_p1) sh1_d = 1'b1;
            else hp1_d = sat_sub(hp1_q, nh2);
          end
          if (cd1_q == 6'd0 && p1_shoot) begin
            if (f1 != '0) begin
              en1_d = a1 | f1;
              cd1_d = cd_load;
            end else drop_d[0] = 1'b1;
          end else if (cd1_q != 6'd0) cd1_d = cd1_q - 6'd1;
          if (cd2_q == 6'd0 && p2_shoot) begin
            if (f2 != '0) begin
              en2_d = a2 | f2;
              cd2_d = cd_load;
            end else drop_d[1] = 1'b1;
          end else if (cd2_q != 6'd0) cd2_d = cd2_q - 6'd1;
          if (hp1_d == '0 || hp2_d == '0) begin
            st_d  = S_OVER;
            win_d = {hp1_d == '0, hp2_d == '0};
            en1_d = '0;      en2_d = '0;
            x1_d = X1_INIT;  x2_d = X2_INIT;
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  // State register; reset drops straight back to the idle field
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= S_IDLE;    win_q <= 2'b00;
      lane1_q <= LANE0;  lane2_q <= LANE0;
      en1_q <= '0;       en2_q <= '0;
      x1_q <= X1_INIT;   x2_q <= X2_INIT;
      hp1_q <= HP0;      hp2_q <= HP0;
      cd1_q <= '0;       cd2_q <= '0;
      sh1_q <= 1'b0;     sh2_q <= 1'b0;
      drop_q <= 2'b00;
    end else begin
      st_q <= st_d;      win_q <= win_d;
      lane1_q <= lane1_d; lane2_q <= lane2_d;
      en1_q <= en1_d;    en2_q <= en2_d;
      x1_q <= x1_d;      x2_q <= x2_d;
      hp1_q <= hp1_d;    hp2_q <= hp2_d;
      cd1_q <= cd1_d;    cd2_q <= cd2_d;
      sh1_q <= sh1_d;    sh2_q <= sh2_d;
      drop_q <= drop_d;
    end
  end

  assign state         = st_q;
  assign winner        = win_q;
  assign p1_lane       = lane1_q;
  assign p2_lane       = lane2_q;
  assign p1_ball_en    = en1_q;
  assign p2_ball_en    = en2_q;
  assign p1_ball_x     = x1_q;
  assign p2_ball_x     = x2_q;
  assign p1_hp         = hp1_q;
  assign p2_hp         = hp2_q;
  assign p1_health_pct = 7'((int'(hp1_q) * 100) / MAX_HP);
  assign p2_health_pct = 7'((int'(hp2_q) * 100) / MAX_HP);
  assign p1_shield     = sh1_q;
  assign p2_shield     = sh2_q;
  assign shot_drop     = drop_q;
endmodule

// File: tb/tb_duel_projectile_engine.sv
// Directed bench for duel_projectile_engine (default parameters).
module tb_duel_projectile_engine;
  logic clk = 1'b0;
  logic reset, tick, start, p1_up, p1_down, p2_up, p2_down, p1_shoot, p2_shoot;
  logic [5:0] cooldown_ticks;
  logic [7:0] shield_thresh_p1, shield_thresh_p2, random_number;
  logic [1:0] state, winner, p1_lane, p2_lane, shot_drop;
  logic [8:0] p1_ball_en, p2_ball_en;
  logic [62:0] p1_ball_x, p2_ball_x;
  logic [2:0] p1_hp, p2_hp;
  logic [6:0] p1_health_pct, p2_health_pct;
  logic p1_shield, p2_shield;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  duel_projectile_engine dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .p1_shoot(p1_shoot), .p2_shoot(p2_shoot), .cooldown_ticks(cooldown_ticks),
    .shield_thresh_p1(shield_thresh_p1), .shield_thresh_p2(shield_thresh_p2),
    .random_number(random_number), .state(state), .winner(winner),
    .p1_lane(p1_lane), .p2_lane(p2_lane), .p1_ball_en(p1_ball_en), .p2_ball_en(p2_ball_en),
    .p1_ball_x(p1_ball_x), .p2_ball_x(p2_ball_x), .p1_hp(p1_hp), .p2_hp(p2_hp),
    .p1_health_pct(p1_health_pct), .p2_health_pct(p2_health_pct),
    .p1_shield(p1_shield), .p2_shield(p2_shield), .shot_drop(shot_drop));

  function automatic logic [6:0] sx1(input int s);
    return p1_ball_x[s*7 +: 7];
  endfunction
  function automatic logic [6:0] sx2(input int s);
    return p2_ball_x[s*7 +: 7];
  endfunction

  task automatic do_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic pulse_move(input logic u1, input logic d1, input logic u2, input logic d2);
    @(negedge clk); p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2;
    @(negedge clk); p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
  endtask

  task automatic reset_start();
    @(negedge clk); reset = 1'b1; p1_shoot = 1'b0; p2_shoot = 1'b0;
    @(negedge clk); reset = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (winner !== 2'b00) begin bad++; $display("FAIL reset_winner got=%0d want=0", winner); end
    total++; if (p1_lane !== 2'd1 || p2_lane !== 2'd1) begin bad++; $display("FAIL reset_lanes got=%0d/%0d want=1/1", p1_lane, p2_lane); end
    total++; if (p1_hp !== 3'd5 || p2_hp !== 3'd5) begin bad++; $display("FAIL reset_hp got=%0d/%0d want=5/5", p1_hp, p2_hp); end
    total++; if (p1_ball_en !== 9'd0 || p2_ball_en !== 9'd0) begin bad++; $display("FAIL reset_en got=%h/%h want=0/0", p1_ball_en, p2_ball_en); end
    total++; if (sx1(0) !== 7'd17 || sx2(8) !== 7'd74) begin bad++; $display("FAIL reset_x got=%0d/%0d want=17/74", sx1(0), sx2(8)); end
    total++; if (p1_health_pct !== 7'd100) begin bad++; $display("FAIL reset_pct got=%0d want=100", p1_health_pct); end
    total++; if (p1_shield !== 1'b0 || p2_shield !== 1'b0 || shot_drop !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b%b%b want=0000", p1_shield, p2_shield, shot_drop); end
    @(negedge clk); reset = 1'b0;
    p1_shoot = 1'b1;
    pulse_move(1'b1, 1'b0, 1'b0, 1'b0);
    do_tick();
    p1_shoot = 1'b0;
    total++; if (p1_lane !== 2'd1 || p1_ball_en !== 9'd0 || state !== 2'b00) begin bad++; $display("FAIL idle_frozen got lane=%0d en=%h st=%0d want 1/0/0", p1_lane, p1_ball_en, state); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++; if (state !== 2'b01) begin bad++; $display("FAIL start_play got=%0d want=1", state); end
  endtask

  task automatic test_fire_cooldown();
    reset_start();
    cooldown_ticks = 6'd4; p1_shoot = 1'b1;
    do_tick();
    total++; if (p1_ball_en !== 9'h008 || sx1(3) !== 7'd17) begin bad++; $display("FAIL first_shot got en=%h x=%0d want 008/17", p1_ball_en, sx1(3)); end
    ticks(4);
    total++; if (p1_ball_en !== 9'h008 || sx1(3) !== 7'd21) begin bad++; $display("FAIL cooldown_hold got en=%h x=%0d want 008/21", p1_ball_en, sx1(3)); end
    do_tick();
    total++; if (p1_ball_en !== 9'h018 || sx1(4) !== 7'd17 || sx1(3) !== 7'd22) begin bad++; $display("FAIL second_shot got en=%h x4=%0d x3=%0d want 018/17/22", p1_ball_en, sx1(4), sx1(3)); end
    p1_shoot = 1'b0;
  endtask

  task automatic test_clash();
    reset_start();
    cooldown_ticks = 6'd1;
    pulse_move(1'b1, 1'b0, 1'b1, 1'b0);
    p1_shoot = 1'b1; p2_shoot = 1'b1;
    do_tick();
    p1_shoot = 1'b0; p2_shoot = 1'b0;
    total++; if (p1_ball_en !== 9'h001 || p2_ball_en !== 9'h001) begin bad++; $display("FAIL clash_fire got=%h/%h want=001/001", p1_ball_en, p2_ball_en); end
    ticks(24);
    total++; if (p1_ball_en !== 9'h001 || p2_ball_en !== 9'h001 || sx1(0) !== 7'd41 || sx2(0) !== 7'd50) begin bad++; $display("FAIL clash_approach got en=%h/%h x=%0d/%0d want 001/001 41/50", p1_ball_en, p2_ball_en, sx1(0), sx2(0)); end
    ticks(2);
    total++; if (p1_ball_en !== 9'h000 || p2_ball_en !== 9'h000 || sx1(0) !== 7'd17 || sx2(0) !== 7'd74) begin bad++; $display("FAIL clash_clear got en=%h/%h x=%0d/%0d want 0/0 17/74", p1_ball_en, p2_ball_en, sx1(0), sx2(0)); end
    total++; if (p1_hp !== 3'd5 || p2_hp !== 3'd5) begin bad++; $display("FAIL clash_hp got=%0d/%0d want=5/5", p1_hp, p2_hp); end
  endtask

  task automatic test_hit_shield();
    reset_start();
    cooldown_ticks = 6'd1; shield_thresh_p2 = 8'd18; shield_thresh_p1 = 8'd0; random_number = 8'd200;
    p1_shoot = 1'b1; do_tick(); p1_shoot = 1'b0;
    ticks(48);
    total++; if (p1_ball_en !== 9'h008 || sx1(3) !== 7'd65 || p2_hp !== 3'd5) begin bad++; $display("FAIL hit_approach got en=%h x=%0d hp=%0d want 008/65/5", p1_ball_en, sx1(3), p2_hp); end
    do_tick();
    total++; if (p1_ball_en !== 9'h000 || p2_hp !== 3'd4 || p2_health_pct !== 7'd80 || p2_shield !== 1'b0) begin bad++; $display("FAIL hit_damage got en=%h hp=%0d pct=%0d sh=%b want 0/4/80/0", p1_ball_en, p2_hp, p2_health_pct, p2_shield); end
    random_number = 8'd10;
    p1_shoot = 1'b1; do_tick(); p1_shoot = 1'b0;
    ticks(48);
    do_tick();
    total++; if (p2_shield !== 1'b1 || p2_hp !== 3'd4 || p1_ball_en !== 9'h000) begin bad++; $display("FAIL hit_shielded got sh=%b hp=%0d en=%h want 1/4/0", p2_shield, p2_hp, p1_ball_en); end
    do_tick();
    total++; if (p2_shield !== 1'b0) begin bad++; $display("FAIL shield_pulse got=%b want=0", p2_shield); end
    p2_shoot = 1'b1; do_tick(); p2_shoot = 1'b0;
    ticks(51);
    total++; if (p2_ball_en !== 9'h008 || sx2(3) !== 7'd23 || p1_hp !== 3'd5) begin bad++; $display("FAIL p2_approach got en=%h x=%0d hp=%0d want 008/23/5", p2_ball_en, sx2(3), p1_hp); end
    do_tick();
    total++; if (p2_ball_en !== 9'h000 || p1_hp !== 3'd4 || p1_health_pct !== 7'd80 || p1_shield !== 1'b0) begin bad++; $display("FAIL p2_hit got en=%h hp=%0d pct=%0d sh=%b want 0/4/80/0", p2_ball_en, p1_hp, p1_health_pct, p1_shield); end
  endtask

  task automatic test_lanes();
    reset_start();
    for (int i = 0; i < 3; i++) pulse_move(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (p1_lane !== 2'd0) begin bad++; $display("FAIL lane_up_sat got=%0d want=0", p1_lane); end
    for (int i = 0; i < 3; i++) pulse_move(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (p1_lane !== 2'd2) begin bad++; $display("FAIL lane_down_sat got=%0d want=2", p1_lane); end
    pulse_move(1'b1, 1'b1, 1'b0, 1'b1);
    total++; if (p1_lane !== 2'd1 || p2_lane !== 2'd2) begin bad++; $display("FAIL lane_updown got=%0d/%0d want=1/2", p1_lane, p2_lane); end
  endtask

  task automatic test_shot_drop();
    reset_start();
    cooldown_ticks = 6'd1;
    pulse_move(1'b1, 1'b0, 1'b0, 1'b0);
    p1_shoot = 1'b1;
    ticks(6);
    total++; if (p1_ball_en !== 9'h007 || shot_drop !== 2'b00) begin bad++; $display("FAIL lane_full got en=%h drop=%b want 007/00", p1_ball_en, shot_drop); end
    do_tick();
    total++; if (shot_drop !== 2'b01 || p1_ball_en !== 9'h007) begin bad++; $display("FAIL drop_first got drop=%b en=%h want 01/007", shot_drop, p1_ball_en); end
    do_tick();
    total++; if (shot_drop !== 2'b01) begin bad++; $display("FAIL drop_retry got=%b want=01", shot_drop); end
    @(negedge clk);
    total++; if (shot_drop !== 2'b00) begin bad++; $display("FAIL drop_pulse got=%b want=00", shot_drop); end
    p1_shoot = 1'b0;
  endtask

  task automatic test_despawn();
    reset_start();
    cooldown_ticks = 6'd1;
    pulse_move(1'b1, 1'b0, 1'b0, 1'b0);
    p1_shoot = 1'b1; do_tick(); p1_shoot = 1'b0;
    ticks(70);
    total++; if (p1_ball_en !== 9'h001 || sx1(0) !== 7'd87) begin bad++; $display("FAIL despawn_edge got en=%h x=%0d want 001/87", p1_ball_en, sx1(0)); end
    do_tick();
    total++; if (p1_ball_en !== 9'h000 || sx1(0) !== 7'd17 || p2_hp !== 3'd5) begin bad++; $display("FAIL despawn got en=%h x=%0d hp=%0d want 0/17/5", p1_ball_en, sx1(0), p2_hp); end
  endtask

  task automatic test_round_over();
    reset_start();
    cooldown_ticks = 6'd1; shield_thresh_p2 = 8'd0; random_number = 8'd200;
    p1_shoot = 1'b1;
    for (int k = 0; k < 600 && state !== 2'b10; k++) do_tick();
    p1_shoot = 1'b0;
    total++; if (state !== 2'b10) begin bad++; $display("FAIL over_timeout got state=%0d want=2", state); end
    total++; if (winner !== 2'b01 || p2_hp !== 3'd0 || p1_hp !== 3'd5) begin bad++; $display("FAIL over_winner got w=%0d hp=%0d/%0d want 1 5/0", winner, p1_hp, p2_hp); end
    total++; if (p1_ball_en !== 9'd0 || p2_ball_en !== 9'd0 || sx1(3) !== 7'd17) begin bad++; $display("FAIL over_clear got en=%h/%h x=%0d want 0/0/17", p1_ball_en, p2_ball_en, sx1(3)); end
    p1_shoot = 1'b1;
    pulse_move(1'b1, 1'b0, 1'b0, 1'b0);
    do_tick();
    p1_shoot = 1'b0;
    total++; if (state !== 2'b10 || p1_lane !== 2'd1 || p1_ball_en !== 9'd0) begin bad++; $display("FAIL over_frozen got st=%0d lane=%0d en=%h want 2/1/0", state, p1_lane, p1_ball_en); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++; if (state !== 2'b01 || winner !== 2'b00 || p1_hp !== 3'd5 || p2_hp !== 3'd5 || p2_lane !== 2'd1) begin bad++; $display("FAIL restart got st=%0d w=%0d hp=%0d/%0d lane=%0d want 1/0/5/5/1", state, winner, p1_hp, p2_hp, p2_lane); end
    p1_shoot = 1'b1;
    pulse_move(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(3);
    @(negedge clk); #2 reset = 1'b1;
    #1;
    total++; if (state !== 2'b00 || p1_ball_en !== 9'd0 || p1_lane !== 2'd1 || p1_hp !== 3'd5 || sx1(0) !== 7'd17) begin bad++; $display("FAIL midflight_reset got st=%0d en=%h lane=%0d hp=%0d x=%0d want 0/0/1/5/17", state, p1_ball_en, p1_lane, p1_hp, sx1(0)); end
    @(negedge clk); reset = 1'b0; p1_shoot = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    p1_shoot = 1'b0; p2_shoot = 1'b0; cooldown_ticks = 6'd1;
    shield_thresh_p1 = 8'd0; shield_thresh_p2 = 8'd0; random_number = 8'd200;
    test_reset();
    test_fire_cooldown();
    test_clash();
    test_hit_shield();
    test_lanes();
    test_shot_drop();
    test_despawn();
    test_round_over();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
